// File: rtl/bram_arbiter_pkg.sv
// Shared constants for the BRAM arbiter: FSM encodings, client indices and
// a small helper for the round-robin pointer.
package bram_arbiter_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    function automatic logic otherClient(input logic client);
        return (client == CLIENT0) ? CLIENT1 : CLIENT0;
    endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Bundle of the two client ports, the BRAM-side port and initDone.
// Handshake: a client raises reqc with stable wrc/addrc/wdatac and keeps them
// until it sees gntc high in the same cycle; that cycle is the transfer. A read
// returns one cycle later, qualified by rvalidc. Dropping reqc before a grant
// withdraws the request.
interface bram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  req0;
    logic                  wr0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  wr1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic                  readEnable;
    logic [ADDR_WIDTH-1:0] readAddress;
    logic [DATA_WIDTH-1:0] readData;
    logic                  writeEnable;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0] writeData;

    logic                  initDone;

    modport slave (
        input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, readData,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
               readEnable, readAddress, writeEnable, writeAddress, writeData,
               initDone
    );

    modport master (
        output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, readData,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
               readEnable, readAddress, writeEnable, writeAddress, writeData,
               initDone
    );

endinterface

// File: rtl/bram_arbiter_rr.sv
// Two-way round-robin selection: a lone requester always wins, a tie goes to
// the client named by ptr. The pointer itself is kept by the parent.
module rr_arbiter_2
    import bram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || ptr == CLIENT0)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-client arbiter in front of a single BRAM: sweeps INIT_VALUE into every
// word after reset, then grants one read or write per cycle round-robin.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic          clock,
    input  logic          reset,
    bram_arbiter_if.slave bus,
    output state_t        debugState
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state;
    state_t                nextState;
    logic [ADDR_WIDTH-1:0] sweepCount;
    logic                  ptr;
    logic                  pendValid;
    logic                  pendOwner;
    logic [ADDR_WIDTH-1:0] holdReadAddr;
    logic [ADDR_WIDTH-1:0] holdWriteAddr;
    logic [DATA_WIDTH-1:0] holdWriteData;

    logic [1:0]            reqVec;
    logic [1:0]            gntVec;
    logic                  grantOwner;
    logic                  selWr;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;
    logic                  rdGrant;
    logic                  wrGrant;

    logic                  readEnable;
    logic [ADDR_WIDTH-1:0] readAddress;
    logic                  writeEnable;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0] writeData;

    // Requests are invisible during the sweep, so nothing is queued in INIT.
    assign reqVec = (state == RUN) ? {bus.req1, bus.req0} : 2'b00;

    rr_arbiter_2 rrArbiter (
        .req (reqVec),
        .ptr (ptr),
        .gnt (gntVec)
    );

    assign grantOwner = gntVec[1] ? CLIENT1 : CLIENT0;
    assign selWr      = (grantOwner == CLIENT1) ? bus.wr1    : bus.wr0;
    assign selAddr    = (grantOwner == CLIENT1) ? bus.addr1  : bus.addr0;
    assign selWdata   = (grantOwner == CLIENT1) ? bus.wdata1 : bus.wdata0;
    assign rdGrant    = (|gntVec) && !selWr;
    assign wrGrant    = (|gntVec) && selWr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= INIT;
            sweepCount    <= '0;
            ptr           <= CLIENT0;
            pendValid     <= 1'b0;
            pendOwner     <= CLIENT0;
            holdReadAddr  <= '0;
            holdWriteAddr <= '0;
            holdWriteData <= '0;
        end else begin
            state <= nextState;
            if (state == INIT) begin
                sweepCount <= sweepCount + 1'b1;
            end
            if (|gntVec) begin
                ptr <= otherClient(grantOwner);
            end
            pendValid <= rdGrant;
            if (rdGrant) begin
                pendOwner <= grantOwner;
            end
            if (writeEnable) begin
                holdWriteAddr <= writeAddress;
                holdWriteData <= writeData;
            end
            if (readEnable) begin
                holdReadAddr <= readAddress;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            INIT:    if (sweepCount == LAST_ADDR) nextState = RUN;
            RUN:     nextState = RUN;
            default: nextState = INIT;
        endcase
    end

    // Reset gates the BRAM strobes directly so they drop the moment it rises.
    always_comb begin
        readEnable   = 1'b0;
        readAddress  = holdReadAddr;
        writeEnable  = 1'b0;
        writeAddress = holdWriteAddr;
        writeData    = holdWriteData;
        if (!reset) begin
            case (state)
                INIT: begin
                    writeEnable  = 1'b1;
                    writeAddress = sweepCount;
                    writeData    = INIT_VALUE;
                end
                RUN: begin
                    if (wrGrant) begin
                        writeEnable  = 1'b1;
                        writeAddress = selAddr;
                        writeData    = selWdata;
                    end
                    if (rdGrant) begin
                        readEnable  = 1'b1;
                        readAddress = selAddr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0         = gntVec[0];
    assign bus.gnt1         = gntVec[1];
    assign bus.rvalid0      = pendValid && (pendOwner == CLIENT0);
    assign bus.rvalid1      = pendValid && (pendOwner == CLIENT1);
    assign bus.rdata0       = bus.readData;
    assign bus.rdata1       = bus.readData;
    assign bus.readEnable   = readEnable;
    assign bus.readAddress  = readAddress;
    assign bus.writeEnable  = writeEnable;
    assign bus.writeAddress = writeAddress;
    assign bus.writeData    = writeData;
    assign bus.initDone     = (state == RUN);
    assign debugState       = state;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: init sweep, arbitration vector table,
// read-data scoreboard and reset corner cases.
module tb_bram_arbiter;
    import bram_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct {
        logic          req0;
        logic          wr0;
        logic [AW-1:0] addr0;
        logic [DW-1:0] wdata0;
        logic          req1;
        logic          wr1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] wdata1;
        logic          gnt0;
        logic          gnt1;
    } vec_t;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    state_t debug_state;

    bram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .INIT_VALUE ('0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .debugState (debug_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    logic [31:0] cyc = '0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // BRAM model: registered read, one-cycle latency
    logic [DW-1:0] mem [256];
    always @(posedge clock) begin
        if (bus.writeEnable) mem[bus.writeAddress] <= bus.writeData;
        if (bus.readEnable) bus.readData <= mem[bus.readAddress];
    end

    // counters and reference state
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DW-1:0] ref_mem [256];
    logic [AW-1:0] exp_ra, exp_wa;
    logic [DW-1:0] exp_wd;
    logic [64:0] exp_q[$];  // {due cycle, client, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // scoreboard: read returns checked against expected queue
    always @(negedge clock) begin
        logic [64:0] e;
        if (!reset) begin
            if (bus.rvalid0 || bus.rvalid1) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", {62'd0, bus.rvalid1, bus.rvalid0}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid_cycle", {32'd0, cyc}, {32'd0, e[64:33]});
                    check("rvalid_owner", {62'd0, bus.rvalid1, bus.rvalid0}, e[32] ? 64'd2 : 64'd1);
                    check("rdata_owner", {32'd0, e[32] ? bus.rdata1 : bus.rdata0}, {32'd0, e[31:0]});
                    check("rdata_other", {32'd0, e[32] ? bus.rdata0 : bus.rdata1}, {32'd0, e[31:0]});
                end
            end else if (exp_q.size() > 0 && exp_q[0][64:33] <= cyc) begin
                e = exp_q.pop_front();
                check("rvalid_missing", 64'd0, 64'd1);
            end
        end
    end

    // driver tasks
    task automatic drive(input vec_t v);
        bus.req0   = v.req0;
        bus.wr0    = v.wr0;
        bus.addr0  = v.addr0;
        bus.wdata0 = v.wdata0;
        bus.req1   = v.req1;
        bus.wr1    = v.wr1;
        bus.addr1  = v.addr1;
        bus.wdata1 = v.wdata1;
    endtask

    task automatic idle();
        vec_t z = '{default: '0};
        drive(z);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"},
              {57'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
               bus.readEnable, bus.writeEnable, bus.initDone}, 64'd0);
        check({name, "_bus"}, {16'd0, bus.readAddress, bus.writeAddress, bus.writeData}, 64'd0);
    endtask

    // Called at posedge+1 just after reset release.
    task automatic check_sweep(input string name);
        int n = 0;
        int bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (bus.initDone) break;
            if (!bus.writeEnable || bus.writeAddress != n[AW-1:0] || bus.writeData != '0 ||
                bus.gnt0 || bus.gnt1 || bus.readEnable || bus.rvalid0 || bus.rvalid1) bad++;
            n++;
        end
        idle();
        check({name, "_len"}, 64'(n), 64'd256);
        check({name, "_bad"}, 64'(bad), 64'd0);
        check({name, "_done"}, {63'd0, bus.initDone}, 64'd1);
        for (int a = 0; a < 256; a++) ref_mem[a] = '0;
        exp_wa = 8'hFF;
        exp_wd = '0;
        exp_ra = '0;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_row(input string name, input vec_t v);
        logic          c;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          exp_we, exp_re;
        drive(v);
        @(negedge clock);
        check({name, "_gnt"}, {62'd0, bus.gnt1, bus.gnt0}, {62'd0, v.gnt1, v.gnt0});
        exp_we = 1'b0;
        exp_re = 1'b0;
        if (v.gnt0 || v.gnt1) begin
            c = v.gnt1;
            w = c ? v.wr1 : v.wr0;
            a = c ? v.addr1 : v.addr0;
            d = c ? v.wdata1 : v.wdata0;
            if (w) begin
                exp_we = 1'b1;
                exp_wa = a;
                exp_wd = d;
                ref_mem[a] = d;
            end else begin
                exp_re = 1'b1;
                exp_ra = a;
                exp_q.push_back({cyc + 32'd1, c, ref_mem[a]});
            end
        end
        check({name, "_en"}, {62'd0, bus.writeEnable, bus.readEnable}, {62'd0, exp_we, exp_re});
        check({name, "_ra"}, 64'(bus.readAddress), 64'(exp_ra));
        check({name, "_wa_wd"}, {24'd0, bus.writeAddress, bus.writeData}, {24'd0, exp_wa, exp_wd});
        @(posedge clock);
        #1;
    endtask

    vec_t vecs [16];

    initial begin
        vec_t v;
        logic saw_rvalid;

        // {req0,wr0,addr0,wdata0, req1,wr1,addr1,wdata1, gnt0,gnt1}
        vecs[0]  = '{1, 1, 8'd4, 32'h11110000, 0, 0, 8'd0, 32'h0,        1, 0};
        vecs[1]  = '{1, 1, 8'd2, 32'hAAAA8888, 0, 0, 8'd0, 32'h0,        1, 0};
        vecs[2]  = '{1, 0, 8'd2, 32'h0,        0, 0, 8'd0, 32'h0,        1, 0};
        vecs[3]  = '{0, 0, 8'd0, 32'h0,        1, 0, 8'd4, 32'h0,        0, 1};
        vecs[4]  = '{0, 0, 8'd0, 32'h0,        0, 0, 8'd0, 32'h0,        0, 0};
        vecs[5]  = '{1, 0, 8'd4, 32'h0,        1, 0, 8'd2, 32'h0,        1, 0};
        vecs[6]  = '{1, 0, 8'd4, 32'h0,        1, 0, 8'd2, 32'h0,        0, 1};
        vecs[7]  = '{1, 0, 8'd4, 32'h0,        1, 0, 8'd2, 32'h0,        1, 0};
        vecs[8]  = '{1, 0, 8'd4, 32'h0,        1, 0, 8'd2, 32'h0,        0, 1};
        vecs[9]  = '{0, 0, 8'd0, 32'h0,        1, 1, 8'd2, 32'd100,      0, 1};
        vecs[10] = '{1, 0, 8'd2, 32'h0,        0, 0, 8'd0, 32'h0,        1, 0};
        vecs[11] = '{1, 1, 8'd5, 32'h55555555, 1, 1, 8'd6, 32'h66666666, 0, 1};
        vecs[12] = '{1, 1, 8'd5, 32'h55555555, 0, 0, 8'd0, 32'h0,        1, 0};
        vecs[13] = '{1, 0, 8'd5, 32'h0,        1, 0, 8'd6, 32'h0,        0, 1};
        vecs[14] = '{1, 0, 8'd5, 32'h0,        0, 0, 8'd0, 32'h0,        1, 0};
        vecs[15] = '{0, 0, 8'd0, 32'h0,        0, 0, 8'd0, 32'h0,        0, 0};

        // reset state, then first sweep with a request held that must be ignored
        idle();
        @(negedge clock);
        check_reset_outputs("reset0");
        bus.req0  = 1'b1;
        bus.addr0 = 8'd9;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_sweep("sweep0");

        // arbitration / read-write table
        for (int i = 0; i < 16; i++) apply_row($sformatf("vec%0d", i), vecs[i]);
        idle();
        repeat (3) @(posedge clock);
        #1;
        check("queue_drained0", 64'(exp_q.size()), 64'd0);

        // reset in the middle of the sweep at address 0x40
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.writeAddress == 8'h40) break;
        end
        check("mid_sweep_addr", 64'(bus.writeAddress), 64'h40);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_init");
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_sweep("sweep_restart");

        // read granted, reset before the edge that would register it
        v = '{1, 0, 8'd3, 32'h0, 0, 0, 8'd0, 32'h0, 1, 0};
        drive(v);
        @(negedge clock);
        check("r2_gnt0", {63'd0, bus.gnt0}, 64'd1);
        reset = 1'b1;
        idle();
        #1;
        check_reset_outputs("reset_run");
        saw_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (bus.rvalid0 || bus.rvalid1) saw_rvalid = 1'b1;
        end
        check_reset_outputs("reset_run_hold");
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (bus.rvalid0 || bus.rvalid1) saw_rvalid = 1'b1;
        end
        check("r2_no_rvalid", {63'd0, saw_rvalid}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_sweep("sweep_after_run");

        // pointer is back on client 0 after reset
        apply_row("post_reset_tie", '{1, 0, 8'd7, 32'h0, 1, 0, 8'd8, 32'h0, 1, 0});
        apply_row("post_reset_c1", '{0, 0, 8'd0, 32'h0, 1, 0, 8'd8, 32'h0, 0, 1});
        idle();
        repeat (3) @(posedge clock);
        #1;
        check("queue_drained1", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
